life_disp: RTL and testbench
============================

// Module: life_disp
// PURPOSE
//  Display back-end for the life array. Consumes the per-column word `col` and the
//  serial cell counter `cnt` produced by the life chip, and assembles them into a
//  double-buffered X-by-Y frame. It scans that frame onto a multiplexed LED matrix,
//  one column at a time, and blinks the cursor cell.
//  Sits directly downstream of life_1 (fed by its col and cnt outputs) and drives
//  the board pins.
// PARAMETERS
//  X          8  columns; must equal 2**LOG2X
//  Y          8  rows; must equal 2**LOG2Y
//  LOG2X      3  column index width
//  LOG2Y      3  row index width
//  DWELL_BITS 10 width of the per-column dwell counter (dwell = 2**DWELL_BITS clocks)
//  BLINK_BITS 5  width of the blink counter (cursor toggles every 2**(BLINK_BITS-1) scans)
// PORTS
//  clk        in   1            system clock, rising edge
//  reset      in   1            asynchronous, active-high
//  cnt        in   LOG2X+LOG2Y  serial cell position from life_1; x=cnt[LOG2X-1:0], y=cnt[MSBs]
//  col        in   Y            column word from life_1, valid per CAPTURE rule
//  cursor_x   in   LOG2X        cursor column
//  cursor_y   in   LOG2Y        cursor row
//  led_row    out  Y            row drive for active column, active-high
//  led_col_n  out  X            column select, one-hot active-low; all ones = blanked
//  frame_tick out  1            1-cycle pulse the cycle after a front-buffer swap
// BEHAVIOUR
//  Reset (async, immediate):
//   - shadow[], front[], scan=0, dwell=0, blink=0 all cleared
//   - led_row=0, led_col_n={X{1'b1}}, frame_tick=0
//  CAPTURE: on any clk where cnt[MSBs]==Y-1, write shadow[cnt[LOG2X-1:0]] <= col.
//   - Other cnt values leave shadow unchanged.
//  SWAP: on the clk where cnt=={LOG2X+LOG2Y{1'b1}}, load front <= shadow.
//   - The column captured in that same cycle is merged in (front[X-1] gets col).
//   - frame_tick=1 on the next cycle only.
//   - cnt stuck at all ones causes a swap every cycle and frame_tick stays high. Legal.
//  SCAN: dwell is a free-running DWELL_BITS counter.
//   - When dwell wraps all-ones->0: scan <= (scan==X-1) ? 0 : scan+1.
//   - On scan wrap X-1->0: blink <= blink+1 (mod 2**BLINK_BITS).
//  OUTPUTS: registered; each cycle they are computed from the state before that edge.
//   - dwell==0 (ghost blank): led_col_n={X{1'b1}}, led_row=0.
//   - otherwise: led_col_n=~(1<<scan); led_row=front[scan] ^ m.
//   - m = (blink MSB && scan==cursor_x) ? (1<<cursor_y) : 0.
//  Cursor moves take effect on the next output register update; no glitch filtering.
//  Frame tearing is prevented: front[] changes only at SWAP, never mid-capture.
//  Swap coinciding with scan advance: the new column is shown with the new front data.
//  Reset asserted mid-scan blanks the outputs immediately (async clear).
//   - After release the first visible column is 0, at dwell==1.
// TESTING
//  1 reset then release, cnt held 0:
//    led_col_n=FF and led_row=00 for the first cycle; at dwell==1 led_col_n=FE, led_row=00.
//  2 capture: sweep cnt 0..63 with col=8'hA5 when x==3, else 00:
//    frame_tick pulses once after cnt=63; when scan==3 led_row=A5, all other columns 00.
//  3 no tearing: change col during the second sweep before cnt reaches 63:
//    led_row keeps the old frame until the cycle after cnt=63.
//  4 cursor blink: cursor=(2,5), empty frame, DWELL_BITS=2, BLINK_BITS=2:
//    led_row=20 at scan==2 only during the scans where blink MSB is 1.
//  5 cursor over a live cell: front[2]=8'h20, cursor=(2,5):
//    led_row at scan 2 alternates 20/00 with blink MSB.
//  6 reset pulse mid-column:
//    led_col_n=FF on the same edge; frame cleared, so led_row=00 until the next SWAP.

Source files
------------

// File: rtl/life_disp.sv
// life_disp -- display back-end for the life array.
//
// Captures the per-column words streamed by life_1 into a shadow frame and
// copies the shadow into the front frame once per generation. The front frame
// is scanned onto a multiplexed LED matrix one column at a time, and the
// cursor cell blinks.
//
// Ports
//    clk        : system clock, rising edge
//    reset      : asynchronous, active-high
//    cnt        : serial cell position from life_1 (x = low LOG2X bits, y = upper bits)
//    col        : column word from life_1, captured while y == Y-1
//    cursor_x   : cursor column
//    cursor_y   : cursor row
//    led_row    : row drive for the active column, active-high
//    led_col_n  : column select, one-hot active-low; all ones = blanked
//    frame_tick : one-cycle pulse the cycle after the front frame is reloaded
module life_disp #(
   parameter int X          = 8,
   parameter int Y          = 8,
   parameter int LOG2X      = 3,
   parameter int LOG2Y      = 3,
   parameter int DWELL_BITS = 10,
   parameter int BLINK_BITS = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [LOG2X+LOG2Y-1:0]   cnt,
   input  logic [Y-1:0]             col,
   input  logic [LOG2X-1:0]         cursor_x,
   input  logic [LOG2Y-1:0]         cursor_y,
   output logic [Y-1:0]             led_row,
   output logic [X-1:0]             led_col_n,
   output logic                     frame_tick
);

   localparam int CW = LOG2X + LOG2Y;

   logic [Y-1:0]            shadow_q [X];
   logic [Y-1:0]            shadow_d [X];
   logic [Y-1:0]            front_q  [X];
   logic [Y-1:0]            front_d  [X];
   logic [LOG2X-1:0]        scan_q, scan_d;
   logic [DWELL_BITS-1:0]   dwell_q, dwell_d;
   logic [BLINK_BITS-1:0]   blink_q, blink_d;
   logic [Y-1:0]            led_row_q, led_row_d;
   logic [X-1:0]            led_col_n_q, led_col_n_d;
   logic                    frame_tick_q, frame_tick_d;

   logic [LOG2X-1:0]        cap_x_s;
   logic [LOG2Y-1:0]        cap_y_s;
   logic                    capture_s;
   logic                    swap_s;
   logic                    dwell_wrap_s;
   logic                    scan_last_s;
   logic [Y-1:0]            mark_s;

   assign cap_x_s      = cnt[LOG2X-1:0];
   assign cap_y_s      = cnt[CW-1:LOG2X];
   assign capture_s    = (cap_y_s == LOG2Y'(Y - 1));
   assign swap_s       = (cnt == {CW{1'b1}});
   assign dwell_wrap_s = (dwell_q == {DWELL_BITS{1'b1}});
   assign scan_last_s  = (scan_q == LOG2X'(X - 1));

   // Frame buffers: capture into shadow, reload front from the updated shadow.
   always_comb begin
      for (int i = 0; i < X; i++) begin
         shadow_d[i] = shadow_q[i];
         front_d[i]  = front_q[i];
         if (capture_s && (cap_x_s == LOG2X'(i))) begin
            shadow_d[i] = col;
         end else begin
            shadow_d[i] = shadow_q[i];
         end
         // Using shadow_d merges the column captured in the swap cycle itself.
         if (swap_s) begin
            front_d[i] = shadow_d[i];
         end else begin
            front_d[i] = front_q[i];
         end
      end
      frame_tick_d = swap_s;
   end

   // Scan timing: free-running dwell, column advance on dwell wrap, blink per full scan.
   always_comb begin
      dwell_d = dwell_q + DWELL_BITS'(1);
      scan_d  = scan_q;
      blink_d = blink_q;
      if (dwell_wrap_s) begin
         if (scan_last_s) begin
            scan_d  = {LOG2X{1'b0}};
            blink_d = blink_q + BLINK_BITS'(1);
         end else begin
            scan_d  = scan_q + LOG2X'(1);
            blink_d = blink_q;
         end
      end else begin
         scan_d  = scan_q;
         blink_d = blink_q;
      end
   end

   // Output drive: dwell==0 is a ghost-blanking slot between columns.
   always_comb begin
      mark_s      = {Y{1'b0}};
      led_row_d   = {Y{1'b0}};
      led_col_n_d = {X{1'b1}};
      if (blink_q[BLINK_BITS-1] && (scan_q == cursor_x)) begin
         mark_s = Y'(1) << cursor_y;
      end else begin
         mark_s = {Y{1'b0}};
      end
      if (dwell_q == {DWELL_BITS{1'b0}}) begin
         led_row_d   = {Y{1'b0}};
         led_col_n_d = {X{1'b1}};
      end else begin
         led_row_d   = front_q[scan_q] ^ mark_s;
         led_col_n_d = ~(X'(1) << scan_q);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < X; i++) begin
            shadow_q[i] <= {Y{1'b0}};
            front_q[i]  <= {Y{1'b0}};
         end
         scan_q       <= {LOG2X{1'b0}};
         dwell_q      <= {DWELL_BITS{1'b0}};
         blink_q      <= {BLINK_BITS{1'b0}};
         led_row_q    <= {Y{1'b0}};
         led_col_n_q  <= {X{1'b1}};
         frame_tick_q <= 1'b0;
      end else begin
         for (int i = 0; i < X; i++) begin
            shadow_q[i] <= shadow_d[i];
            front_q[i]  <= front_d[i];
         end
         scan_q       <= scan_d;
         dwell_q      <= dwell_d;
         blink_q      <= blink_d;
         led_row_q    <= led_row_d;
         led_col_n_q  <= led_col_n_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign led_row    = led_row_q;
   assign led_col_n  = led_col_n_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_life_disp.sv
// Self-checking bench for life_disp (X=Y=8, DWELL_BITS=2, BLINK_BITS=2).
module tb_life_disp;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] cnt = 6'd0;
   logic [7:0] col = 8'h00;
   logic [2:0] cursor_x = 3'd0;
   logic [2:0] cursor_y = 3'd0;
   logic [7:0] led_row;
   logic [7:0] led_col_n;
   logic       frame_tick;

   int errors = 0;
   int checks = 0;

   life_disp #(
      .X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .DWELL_BITS(2), .BLINK_BITS(2)
   ) dut (
      .clk(clk), .reset(reset), .cnt(cnt), .col(col),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .led_row(led_row), .led_col_n(led_col_n), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Reference model: timing derived from cycles since reset
   // (dwell = t mod 4, column = (t/4) mod 8, blink = (t/32) mod 4).
   int unsigned t_m;
   logic [7:0]  sh_m [8];
   logic [7:0]  fr_m [8];
   logic [7:0]  exp_row;
   logic [7:0]  exp_coln;
   logic        exp_tick;

   function automatic logic [2:0] col_of(input int unsigned t);
      return 3'((t / 4) % 8);
   endfunction

   function automatic logic [7:0] cursor_mark(input int unsigned t, input logic [2:0] cx,
                                              input logic [2:0] cy);
      if (((t / 32) % 4) >= 2 && col_of(t) == cx) return 8'h01 << cy;
      return 8'h00;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         t_m      <= 0;
         exp_row  <= 8'h00;
         exp_coln <= 8'hFF;
         exp_tick <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            sh_m[i] <= 8'h00;
            fr_m[i] <= 8'h00;
         end
      end else begin
         t_m      <= t_m + 1;
         exp_tick <= (cnt == 6'd63);
         if ((t_m % 4) == 0) begin
            exp_coln <= 8'hFF;
            exp_row  <= 8'h00;
         end else begin
            exp_coln <= ~(8'h01 << col_of(t_m));
            exp_row  <= fr_m[col_of(t_m)] ^ cursor_mark(t_m, cursor_x, cursor_y);
         end
         if ((cnt / 6'd8) == 6'd7) sh_m[3'(cnt % 6'd8)] <= col;
         if (cnt == 6'd63) begin
            for (int i = 0; i < 8; i++) fr_m[i] <= (i == 7) ? col : sh_m[i];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // One clock, then compare every output against the model on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      chk("model", 32'({frame_tick, led_col_n, led_row}), 32'({exp_tick, exp_coln, exp_row}));
   endtask

   // Advance (bounded) until column c is being driven.
   task automatic wait_col(input logic [2:0] c);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 64 && !found; k++) begin
         tick();
         if (led_col_n == ~(8'h01 << c)) found = 1'b1;
      end
      chk("reach_col", 32'(found), 32'd1);
   endtask

   task automatic sweep(input logic [7:0] v, input logic [2:0] xsel, input logic all_cols,
                        input int last);
      for (int i = 0; i <= last; i++) begin
         cnt = 6'(i);
         col = (all_cols || (i % 8) == xsel) ? v : 8'h00;
         tick();
      end
      cnt = 6'd0;
      col = 8'h00;
   endtask

   // Count column-2 slots showing 20 vs 00 over one full blink period (128 cycles).
   task automatic blink_window(input string nm);
      int n20, n00;
      n20 = 0;
      n00 = 0;
      for (int k = 0; k < 128; k++) begin
         tick();
         if (led_col_n == 8'hFB) begin
            if (led_row == 8'h20) n20++;
            else if (led_row == 8'h00) n00++;
         end
      end
      chk({nm, "_on"}, 32'(n20), 32'd6);
      chk({nm, "_off"}, 32'(n00), 32'd6);
   endtask

   typedef struct {
      logic [5:0] cnt;
      logic [7:0] col;
      logic       exp_tick;
   } vec_t;

   vec_t vt[$];

   initial begin
      int nz;
      // Capture sweep: A5 on x==3, then cnt stuck at all ones, then idle.
      for (int i = 0; i < 64; i++) vt.push_back('{6'(i), ((i % 8) == 3) ? 8'hA5 : 8'h00, (i == 63)});
      vt.push_back('{6'd0, 8'h00, 1'b0});
      vt.push_back('{6'd1, 8'h00, 1'b0});

      // Reset then release, cnt held 0.
      #2 reset = 1'b1;
      #1;
      chk("reset_coln", 32'(led_col_n), 32'hFF);
      chk("reset_row", 32'(led_row), 32'h00);
      chk("reset_tick", 32'(frame_tick), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("first_blank", 32'({led_col_n, led_row}), 32'hFF00);
      tick();
      chk("first_col0", 32'({led_col_n, led_row}), 32'hFE00);

      // Table-driven capture sweep.
      foreach (vt[i]) begin
         cnt = vt[i].cnt;
         col = vt[i].col;
         tick();
         chk("frame_tick", 32'(frame_tick), 32'(vt[i].exp_tick));
      end
      cnt = 6'd0;
      wait_col(3'd3);
      chk("cap_col3", 32'(led_row), 32'hA5);
      wait_col(3'd5);
      chk("cap_col5", 32'(led_row), 32'h00);

      // cnt stuck at all ones keeps frame_tick high.
      cnt = 6'd63;
      col = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stuck_tick", 32'(frame_tick), 32'h1);
      end
      cnt = 6'd0;
      tick();
      chk("stuck_release", 32'(frame_tick), 32'h0);

      // Refill A5 at column 3, then a torn-frame attempt with FF everywhere.
      sweep(8'hA5, 3'd3, 1'b0, 63);
      sweep(8'hFF, 3'd0, 1'b1, 62);
      wait_col(3'd3);
      chk("tear_col3_old", 32'(led_row), 32'hA5);
      wait_col(3'd6);
      chk("tear_col6_old", 32'(led_row), 32'h00);
      cnt = 6'd63;
      col = 8'hFF;
      tick();
      chk("tear_swap_tick", 32'(frame_tick), 32'h1);
      cnt = 6'd0;
      col = 8'h00;
      wait_col(3'd3);
      chk("tear_col3_new", 32'(led_row), 32'hFF);
      wait_col(3'd6);
      chk("tear_col6_new", 32'(led_row), 32'hFF);

      // Cursor blink on an empty frame, then over a live cell.
      cursor_x = 3'd2;
      cursor_y = 3'd5;
      sweep(8'h00, 3'd0, 1'b1, 63);
      blink_window("blink_empty");
      sweep(8'h20, 3'd2, 1'b0, 63);
      blink_window("blink_live");

      // Reset pulse in the middle of a visible column.
      wait_col(3'd2);
      #2 reset = 1'b1;
      #1;
      chk("midreset_coln", 32'(led_col_n), 32'hFF);
      chk("midreset_row", 32'(led_row), 32'h00);
      @(negedge clk);
      reset = 1'b0;
      nz = 0;
      for (int k = 0; k < 32; k++) begin
         tick();
         if (led_row != 8'h00) nz++;
      end
      chk("midreset_cleared", 32'(nz), 32'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 2000; k++) begin
         case ($urandom_range(0, 9))
            0: cnt = 6'($urandom);
            1: cnt = 6'd63;
            default: cnt = cnt + 6'd1;
         endcase
         col = 8'($urandom);
         if ($urandom_range(0, 63) == 0) begin
            cursor_x = 3'($urandom);
            cursor_y = 3'($urandom);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
